// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and FSM state encodings for the PWM capture block
package pwm_pkg;

   localparam int CTR_LEN_DEF  = 16;
   localparam int FILT_LEN_DEF = 3;

   typedef logic [1:0] pwm_state_t;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HIGH = 2'd1;
   localparam logic [1:0] ST_LOW  = 2'd2;

endpackage

// File: rtl/pwm_capture_if.sv
// rtl/pwm_capture_if.sv - measurement result bus (width/period/valid/timeout) of pwm_capture
interface pwm_capture_if
   import pwm_pkg::*;
#(
   parameter int CTR_LEN = CTR_LEN_DEF
);

   logic [CTR_LEN-1:0] width;
   logic [CTR_LEN-1:0] period;
   logic               valid;
   logic               timeout;

   modport master (output width, output period, output valid, output timeout);
   modport slave  (input  width, input  period, input  valid, input  timeout);

endinterface

// File: rtl/pwm_edge_sync.sv
// rtl/pwm_edge_sync.sv - pwm_in synchronizer, optional glitch filter and registered edge detect
// Optional filter enabled by macro PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_edge_sync
   import pwm_pkg::*;
#(
   parameter int FILT_LEN = FILT_LEN_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   if (FILT_LEN < 1) begin : g_bad_filt_len
      $error("pwm_edge_sync: FILT_LEN must be at least 1");
   end

   logic s1;
   logic sync;
   logic sv1;
   logic sv2;
   logic seen_low;
   logic src;
   logic src_d;

   // sv1/sv2 mark when sync holds a real sample rather than its reset value;
   // rises are only trusted once a genuine low has been seen, so a pulse
   // already high when reset releases is never mistaken for an edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1       <= 1'b0;
         sync     <= 1'b0;
         sv1      <= 1'b0;
         sv2      <= 1'b0;
         seen_low <= 1'b0;
      end else begin
         s1       <= din;
         sync     <= s1;
         sv1      <= 1'b1;
         sv2      <= sv1;
         seen_low <= seen_low | (sv2 & ~sync);
      end
   end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   localparam int FCW = $clog2(FILT_LEN + 1);

   logic           filt;
   logic [FCW-1:0] fcnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         filt <= 1'b0;
         fcnt <= '0;
      end else if (sync == filt) begin
         fcnt <= '0;
      end else if (fcnt == FCW'(FILT_LEN - 1)) begin
         filt <= sync;
         fcnt <= '0;
      end else begin
         fcnt <= fcnt + 1'b1;
      end
   end

   assign src = filt;
`else
   assign src = sync;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         src_d <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         src_d <= src;
         rise  <= seen_low & src & ~src_d;
         fall  <= src_d & ~src;
      end
   end

   assign level = src_d;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM high-time and period capture with saturation timeout
// Optional input glitch filter enabled by macro PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int CTR_LEN  = CTR_LEN_DEF,
   parameter int FILT_LEN = FILT_LEN_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           pwm_in,
   pwm_capture_if.master  cap
);

   localparam logic [CTR_LEN-1:0] CNT_MAX = '1;
   localparam logic [CTR_LEN-1:0] CNT_ONE = {{(CTR_LEN-1){1'b0}}, 1'b1};

   logic level_unused;
   logic rise;
   logic fall;

   pwm_state_t         state;
   logic [CTR_LEN-1:0] hi_cnt;
   logic [CTR_LEN-1:0] per_cnt;
   logic [CTR_LEN-1:0] width_q;
   logic [CTR_LEN-1:0] period_q;
   logic               valid_q;
   logic               timeout_q;

   pwm_edge_sync #(
      .FILT_LEN (FILT_LEN)
   ) u_edge (
      .clk   (clk),
      .rst   (rst),
      .din   (pwm_in),
      .level (level_unused),
      .rise  (rise),
      .fall  (fall)
   );

   // The edge cycle is the first cycle of the new phase, so counters restart
   // at 1 on a rise and hi_cnt stops before the fall cycle is counted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         hi_cnt    <= '0;
         per_cnt   <= '0;
         width_q   <= '0;
         period_q  <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               hi_cnt  <= '0;
               per_cnt <= '0;
               if (rise) begin
                  state   <= ST_HIGH;
                  hi_cnt  <= CNT_ONE;
                  per_cnt <= CNT_ONE;
               end
            end
            ST_HIGH: begin
               if (per_cnt == CNT_MAX) begin
                  timeout_q <= 1'b1;
                  state     <= ST_IDLE;
                  hi_cnt    <= '0;
                  per_cnt   <= '0;
               end else if (fall) begin
                  state   <= ST_LOW;
                  per_cnt <= per_cnt + CNT_ONE;
               end else begin
                  hi_cnt  <= hi_cnt + CNT_ONE;
                  per_cnt <= per_cnt + CNT_ONE;
               end
            end
            ST_LOW: begin
               // A rise on the saturation cycle still closes a valid period.
               if (rise) begin
                  width_q  <= hi_cnt;
                  period_q <= per_cnt;
                  valid_q  <= 1'b1;
                  state    <= ST_HIGH;
                  hi_cnt   <= CNT_ONE;
                  per_cnt  <= CNT_ONE;
               end else if (per_cnt == CNT_MAX) begin
                  timeout_q <= 1'b1;
                  state     <= ST_IDLE;
                  hi_cnt    <= '0;
                  per_cnt   <= '0;
               end else begin
                  per_cnt <= per_cnt + CNT_ONE;
               end
            end
            default: begin
               state   <= ST_IDLE;
               hi_cnt  <= '0;
               per_cnt <= '0;
            end
         endcase
      end
   end

   assign cap.width   = width_q;
   assign cap.period  = period_q;
   assign cap.valid   = valid_q;
   assign cap.timeout = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - self-checking bench for pwm_capture against a waveform-level reference model
module tb_pwm_capture;
   import pwm_pkg::*;

   localparam int CL   = 8;
   localparam int FL   = 3;
   localparam int MAXV = (1 << CL) - 1;
   localparam int LAT  = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic pwm_in = 1'b0;

   always #5 clk = ~clk;

   pwm_capture_if #(.CTR_LEN(CL)) cap ();

   pwm_capture #(
      .CTR_LEN  (CL),
      .FILT_LEN (FL)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .pwm_in (pwm_in),
      .cap    (cap)
   );

   typedef struct {
      bit is_to;
      int stamp;
      int w;
      int p;
   } ev_t;

   int  checks = 0;
   int  errors = 0;
   bit  wave[$];
   ev_t act_q[$];
   ev_t exp_q[$];

   task automatic add_seg(input bit lvl, input int n);
      for (int i = 0; i < n; i++) wave.push_back(lvl);
   endtask

   task automatic add_period(input int h, input int l);
      add_seg(1'b1, h);
      add_seg(1'b0, l);
   endtask

   // Reference: find rising/falling edges of the (optionally filtered) input,
   // a period closes on the next rise if it came within MAXV cycles, else it
   // is abandoned with a timeout MAXV cycles after its rise.
   task automatic build_expected(input bit prev);
      bit  f[$];
      bit  acc;
      int  run;
      bit  last;
      bit  meas;
      int  r0;
      int  fall_t;
      ev_t e;
      acc = prev;
      run = 0;
      for (int k = 0; k < wave.size(); k++) begin
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
         f.push_back(acc);
         if (wave[k] != acc) begin
            run++;
            if (run == FL) begin
               acc = wave[k];
               run = 0;
            end
         end else begin
            run = 0;
         end
`else
         f.push_back(wave[k]);
`endif
      end
      last = prev;
      meas = 1'b0;
      r0 = 0;
      fall_t = 0;
      for (int k = 0; k < f.size(); k++) begin
         if (f[k] && !last) begin
            if (meas) begin
               e.is_to = 1'b0; e.stamp = k + LAT; e.w = fall_t - r0; e.p = k - r0;
               exp_q.push_back(e);
            end
            meas = 1'b1;
            r0 = k;
         end else begin
            if (!f[k] && last) fall_t = k;
            if (meas && (k - r0) == MAXV) begin
               e.is_to = 1'b1; e.stamp = k + LAT; e.w = 0; e.p = 0;
               exp_q.push_back(e);
               meas = 1'b0;
            end
         end
         last = f[k];
      end
   endtask

   task automatic run_wave(input bit prev, input string name);
      logic [CL-1:0] pw;
      logic [CL-1:0] pp;
      int  both_cnt;
      int  drift_cnt;
      int  n;
      ev_t e;
      act_q.delete();
      exp_q.delete();
      both_cnt = 0;
      drift_cnt = 0;
      pw = '0;
      pp = '0;
      for (int k = 0; k < wave.size(); k++) begin
         @(negedge clk);
         if (cap.valid && cap.timeout) both_cnt++;
         if (k > 0 && !cap.valid && (cap.width !== pw || cap.period !== pp)) drift_cnt++;
         if (cap.valid) begin
            e.is_to = 1'b0; e.stamp = k; e.w = int'(cap.width); e.p = int'(cap.period);
            act_q.push_back(e);
         end
         if (cap.timeout) begin
            e.is_to = 1'b1; e.stamp = k; e.w = 0; e.p = 0;
            act_q.push_back(e);
         end
         pw = cap.width;
         pp = cap.period;
         pwm_in = wave[k];
      end
      build_expected(prev);
      checks++;
      if (act_q.size() != exp_q.size())
         $display("FAIL %s event_count: got %0d, expected %0d", name, act_q.size(), exp_q.size());
      else ;
      if (act_q.size() != exp_q.size()) errors++;
      n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         if (act_q[i].is_to !== exp_q[i].is_to || act_q[i].stamp != exp_q[i].stamp ||
             act_q[i].w != exp_q[i].w || act_q[i].p != exp_q[i].p) begin
            errors++;
            $display("FAIL %s event%0d: got timeout=%0d t=%0d w=%0d p=%0d, expected timeout=%0d t=%0d w=%0d p=%0d",
                     name, i, act_q[i].is_to, act_q[i].stamp, act_q[i].w, act_q[i].p,
                     exp_q[i].is_to, exp_q[i].stamp, exp_q[i].w, exp_q[i].p);
         end
      end
      checks++;
      if (both_cnt != 0) begin
         errors++;
         $display("FAIL %s valid_and_timeout: got %0d overlapping cycles, expected 0", name, both_cnt);
      end
      checks++;
      if (drift_cnt != 0) begin
         errors++;
         $display("FAIL %s output_stable: got %0d changes outside valid, expected 0", name, drift_cnt);
      end
      wave.delete();
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (cap.width !== 8'd0 || cap.period !== 8'd0) begin
         errors++;
         $display("FAIL reset_values: got width=%0d period=%0d, expected 0 0", cap.width, cap.period);
      end
      checks++;
      if (cap.valid !== 1'b0 || cap.timeout !== 1'b0) begin
         errors++;
         $display("FAIL reset_pulses: got valid=%b timeout=%b, expected 0 0", cap.valid, cap.timeout);
      end
      checks++;
      if (dut.state !== ST_IDLE) begin
         errors++;
         $display("FAIL reset_state: got %0d, expected %0d", dut.state, ST_IDLE);
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_periodic();
      add_seg(1'b0, 10);
      for (int i = 0; i < 6; i++) add_period(3, 5);
      add_seg(1'b0, 300);
      run_wave(1'b0, "periodic_3_5");
   endtask

   task automatic test_random();
      for (int r = 0; r < 3; r++) begin
         add_seg(1'b0, 10);
         for (int i = 0; i < 8; i++) begin
            if (r == 2) add_period($urandom_range(3, 150), $urandom_range(3, 150));
            else        add_period($urandom_range(3, 60), $urandom_range(3, 60));
         end
         add_seg(1'b0, 300);
         run_wave(1'b0, $sformatf("random%0d", r));
      end
   endtask

   task automatic test_const_high();
      add_seg(1'b0, 10);
      add_seg(1'b1, 300);
      add_seg(1'b0, 300);
      run_wave(1'b0, "const_high");
      checks++;
      if (dut.state !== ST_IDLE) begin
         errors++;
         $display("FAIL const_high_state: got %0d, expected %0d", dut.state, ST_IDLE);
      end
   endtask

   task automatic test_boundary();
      add_seg(1'b0, 10);
      for (int i = 0; i < 3; i++) add_period(100, 155);
      for (int i = 0; i < 2; i++) add_period(100, 157);
      add_period(100, 156);
      for (int i = 0; i < 2; i++) add_period(100, 155);
      add_seg(1'b0, 300);
      run_wave(1'b0, "boundary");
   endtask

   task automatic test_glitch();
      add_seg(1'b0, 10);
      add_period(4, 8);
      add_seg(1'b1, 4);
      add_seg(1'b0, 3);
      add_seg(1'b1, 1);
      add_seg(1'b0, 4);
      add_period(4, 8);
      add_period(4, 8);
      add_seg(1'b0, 300);
      run_wave(1'b0, "glitch");
   endtask

   task automatic test_reset_mid();
      add_seg(1'b0, 10);
      add_period(5, 7);
      add_period(5, 7);
      add_seg(1'b1, 8);
      run_wave(1'b0, "pre_reset");
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (cap.width !== 8'd0 || cap.period !== 8'd0 || cap.valid !== 1'b0 || cap.timeout !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got width=%0d period=%0d valid=%b timeout=%b, expected all 0",
                  cap.width, cap.period, cap.valid, cap.timeout);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      add_seg(1'b1, 10);
      add_seg(1'b0, 7);
      for (int i = 0; i < 3; i++) add_period(5, 7);
      add_seg(1'b0, 300);
      run_wave(1'b1, "post_reset");
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_periodic();
      test_random();
      test_const_high();
      test_boundary();
      test_glitch();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter CTR_LEN, default 16: width of the width/period counters and outputs.
REQ-002 Parameter FILT_LEN, default 3: number of stable samples the glitch filter requires; ignored when the filter is compiled out.
REQ-003 clk  input  1  single clock; every flop in the block is on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 pwm_in  input  1  PWM signal asynchronous to clk.
REQ-006 width  output  CTR_LEN  high time of the last complete period, in clk cycles.
REQ-007 period  output  CTR_LEN  rising-edge-to-rising-edge time of the last complete period, in clk cycles.
REQ-008 valid  output  1  one-cycle pulse when width/period are updated.
REQ-009 timeout  output  1  one-cycle pulse when a measurement is abandoned on counter saturation.

Function
REQ-010 pwm_in SHALL pass through a 2-flop synchronizer; all edge detection SHALL use the synchronized level (sync) and its 1-cycle delayed copy.
REQ-011 The FSM SHALL have exactly three states: IDLE, HIGH and LOW.
REQ-012 IDLE: counters held at 0; a rising edge of sync goes to HIGH with hi_cnt=1 and per_cnt=1; a partial pulse present at reset is discarded.
REQ-013 HIGH: each cycle hi_cnt++ and per_cnt++; a falling edge goes to LOW and freezes hi_cnt.
REQ-014 LOW: each cycle per_cnt++; a rising edge loads width<=hi_cnt, period<=per_cnt, asserts valid for that one cycle, and goes to HIGH with hi_cnt=1 and per_cnt=1.
REQ-015 The edge cycle itself SHALL count as the first cycle of the new phase, so a signal high H cycles and low L cycles yields width=H and period=H+L exactly.
REQ-016 Latency SHALL be 3 clk cycles from the pwm_in rising edge (sampled by the first sync flop) to valid=1 when the filter is compiled out.
REQ-017 If per_cnt reaches 2^CTR_LEN-1 in HIGH or LOW, the FSM SHALL pulse timeout for one cycle and go to IDLE; width and period SHALL keep their last values.
REQ-018 Constant-high or constant-low input SHALL therefore produce timeout, never valid, and SHALL never wrap the counters.
REQ-019 A rising edge in the same cycle as saturation SHALL take priority: valid asserts, timeout does not.
REQ-020 width and period SHALL change only in a valid cycle; valid and timeout SHALL never both be 1.

Reset
REQ-021 When rst=0: state=IDLE, synchronizer and filter flops=0, counters=0, width=0, period=0, valid=0, timeout=0, all asynchronously.
REQ-022 Reset asserted mid-measurement SHALL discard the partial period; after release, the first valid SHALL require two full rising edges.

Configuration
REQ-023 Macro PWM_CAPTURE_GLITCH_FILTER_EN: when defined, the synchronized level SHALL feed a filter that accepts a level change only after FILT_LEN consecutive equal samples, and the FSM SHALL use the filter output.
REQ-024 With the filter, pulses shorter than FILT_LEN cycles SHALL be ignored and latency SHALL grow by FILT_LEN cycles; measured width/period are unchanged for clean input.
REQ-025 Without the macro, no filter logic SHALL exist and REQ-016 latency applies.

Structure
REQ-026 A shared package pwm_pkg SHALL hold the FSM state encodings (IDLE/HIGH/LOW) and the default CTR_LEN/FILT_LEN constants.
REQ-027 The synchronizer, optional filter and edge detect SHALL live in sub-module pwm_edge_sync, with outputs level, rise and fall.
REQ-028 pwm_capture SHALL contain the FSM, counters and output registers.

Verification
REQ-029 Periodic input, high 3 cycles and low 5 cycles, CTR_LEN=8 -> after the second rising edge, valid every 8 cycles with width=3, period=8.
REQ-030 pwm_in held high, CTR_LEN=8 -> exactly one timeout pulse 255 cycles after the first rise, FSM in IDLE, no valid.
REQ-031 rst pulsed low mid-HIGH phase -> all outputs 0 immediately; first valid only after two subsequent rising edges, with correct values.
REQ-032 Filter defined, FILT_LEN=3, 1-cycle glitch during LOW -> no extra valid, width/period unchanged; macro undefined -> glitch measured as width=1.
REQ-033 Input period 257 cycles, CTR_LEN=8 -> timeout, never valid; period 255 -> valid with period=255 (edge wins over saturation).
